da_wave_ctrl: RTL and testbench
===============================

// Module: da_wave_ctrl
// PURPOSE
//   Phase-accumulator sequencer for the 8-bit high-speed DA path.
//   - Generates read addresses for a synchronous waveform ROM holding NUM_WAVES tables of 2**ADDR_W samples.
//   - Sequences continuous or burst playback with start/stop control.
//   - Registers ROM data into the DA sample; the DA itself is clocked by ~clk.
//   - Replaces the fixed divide-counter addressing with a programmable frequency tuning word and a handshaked config port.
// PARAMETERS
//   ADDR_W   8    samples per table = 2**ADDR_W
//   WAVE_W   2    table-select width; NUM_WAVES = 2**WAVE_W
//   PHASE_W  24   phase accumulator width (PHASE_W > ADDR_W)
//   BURST_W  16   burst period counter width
//   MID      8'h80  DA idle/midscale code
// PORTS
//   clk        in   1                 system clock
//   rst_n      in   1                 async reset, active low
//   cfg_valid  in   1                 config offer
//   cfg_ready  out  1                 config accepted when valid&ready
//   cfg_ftw    in   PHASE_W           frequency tuning word (phase step per clk)
//   cfg_wave   in   WAVE_W            table select
//   cfg_burst  in   BURST_W           periods to play; 0 = continuous
//   start      in   1                 level-sampled start request
//   stop       in   1                 graceful stop request
//   rom_addr   out  WAVE_W+ADDR_W     ROM address {wave, phase MSBs}, registered
//   rom_data   in   8                 ROM data, valid 1 clk after rom_addr
//   da_data    out  8                 DA sample, registered
//   busy       out  1                 high in RUN/DRAIN
//   done       out  1                 1-clk pulse at return to IDLE
// BEHAVIOUR
//   Reset: state=IDLE, phase=0, rom_addr=0, da_data=MID, busy=0, done=0, cfg_ready=1; shadow cfg ftw=0, wave=0, burst=0.
//   States: IDLE -> RUN -> DRAIN -> IDLE.
//   IDLE:
//     - cfg_ready=1; cfg_valid captures ftw/wave/burst into shadow regs.
//     - start with shadow ftw!=0: phase<=0, period_cnt<=0, rom_addr<={wave,0}, go RUN.
//     - start with ftw==0: ignored, stays IDLE.
//     - cfg_valid and start in the same clk: new config captured and used by this start (bypass).
//   RUN:
//     - cfg_ready=0.
//     - Each clk: phase<=phase+ftw (mod 2**PHASE_W); rom_addr<={wave, next_phase[PHASE_W-1 -: ADDR_W]}.
//     - Period wrap = carry out of the phase add.
//     - On wrap, period_cnt<=period_cnt+1.
//     - If burst!=0 and the incremented count == burst: go DRAIN.
//     - stop (sticky stop_pend, cleared on leaving RUN): go DRAIN at the next wrap, not immediately.
//     - Stop and burst-end on the same wrap: single DRAIN.
//   DRAIN:
//     - rom_addr held.
//     - Stays 2 clks so the last ROM sample reaches da_data.
//     - Then IDLE with done=1 for exactly 1 clk.
//   da_data pipeline:
//     - 2-stage valid pipe v1<=(state==RUN), v2<=v1.
//     - da_data<=v1 ? rom_data : MID.
//     - First sample reaches da_data 2 clks after RUN entry.
//     - Returns to MID 1 clk after the last ROM sample.
//   Output frequency: f_out = f_clk * ftw / 2**PHASE_W.
//   Boundaries:
//     - ftw >= 2**(PHASE_W-1) may wrap every clk; a wrap is counted every time it occurs.
//     - burst=0 never ends without stop.
//     - period_cnt saturates at burst, never wraps.
//   Reset mid-RUN: immediate return to reset values; no done pulse.
// STRUCTURE
//   Package da_wave_pkg:
//     - state enum {IDLE, RUN, DRAIN}
//     - MID code
//     - default widths
//   Sub-module da_phase_acc: phase register + adder + carry (wrap) output, with clear and enable.
//   Rest (FSM, shadow cfg, burst counter, DA pipe) in da_wave_ctrl.
//   ROM stays external.
// TESTING
//   1. ftw=2**16, wave=1, burst=0, start:
//      - rom_addr steps 0x100,0x101,... once per clk.
//      - da_data = ROM[rom_addr] 2 clks later.
//      - wraps every 256 clks.
//   2. burst=3, ftw=2**17:
//      - exactly 3 wraps (384 clks of RUN).
//      - DRAIN 2 clks, done pulse once, busy low.
//      - da_data = 0x80 after.
//   3. Continuous run, stop pulsed mid-period:
//      - RUN continues to the next wrap, then DRAIN/done.
//      - no sample truncated mid-table.
//   4. cfg_valid+start same clk in IDLE (ftw=2**18):
//      - new ftw used (addr step 4).
//      - cfg_valid during RUN ignored, cfg_ready=0.
//   5. start with ftw=0:
//      - stays IDLE, busy=0, da_data=0x80.
//   6. rst_n low mid-RUN:
//      - rom_addr=0, da_data=0x80, busy=0, no done.
//      - restart after release behaves like test 1.

Source files
------------

// File: rtl/da_wave_pkg.sv
// Shared types and defaults for the DA waveform sequencer: FSM states,
// idle midscale code and default datapath widths.
package da_wave_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int WAVE_W_DEF  = 2;
    localparam int PHASE_W_DEF = 24;
    localparam int BURST_W_DEF = 16;

    localparam logic [7:0] DA_MID = 8'h80;

    // Clocks spent in DRAIN so the final ROM read reaches da_data.
    localparam int DRAIN_CLKS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/da_phase_acc.sv
// Phase accumulator: phase register plus tuning-word adder whose carry out
// marks the completion of one output period.
module da_phase_acc
    import da_wave_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [PHASE_W-1:0] ftw,
    output logic [ADDR_W-1:0]  next_msb,
    output logic               wrap
);

    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W:0]   sum;

    assign sum      = {1'b0, phase_reg} + {1'b0, ftw};
    assign next_msb = sum[PHASE_W-1 -: ADDR_W];
    // A carry only counts as a wrap while the accumulator is actually stepping.
    assign wrap     = enable & sum[PHASE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (clear) begin
            phase_reg <= '0;
        end else if (enable) begin
            phase_reg <= sum[PHASE_W-1:0];
        end
    end

endmodule

// File: rtl/da_wave_ctrl.sv
// Phase-accumulator sequencer for the 8-bit DA path: addresses an external
// synchronous waveform ROM and registers its data into the DA sample.
module da_wave_ctrl
    import da_wave_pkg::*;
#(
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter int         WAVE_W  = WAVE_W_DEF,
    parameter int         PHASE_W = PHASE_W_DEF,
    parameter int         BURST_W = BURST_W_DEF,
    parameter logic [7:0] MID     = DA_MID
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [PHASE_W-1:0]       cfg_ftw,
    input  logic [WAVE_W-1:0]        cfg_wave,
    input  logic [BURST_W-1:0]       cfg_burst,
    input  logic                     start,
    input  logic                     stop,
    output logic [WAVE_W+ADDR_W-1:0] rom_addr,
    input  logic [7:0]               rom_data,
    output logic [7:0]               da_data,
    output logic                     busy,
    output logic                     done
);

    state_t state_reg, state_next;

    logic [PHASE_W-1:0]       ftw_reg;
    logic [WAVE_W-1:0]        wave_reg;
    logic [BURST_W-1:0]       burst_reg;
    logic [BURST_W-1:0]       period_cnt_reg;
    logic [BURST_W-1:0]       cnt_inc;
    logic                     stop_pend_reg;
    logic                     drain_cnt_reg;
    logic                     done_reg;
    logic                     v1_reg;
    logic [7:0]               da_data_reg;
    logic [WAVE_W+ADDR_W-1:0] rom_addr_reg;

    logic                     cfg_fire;
    logic [PHASE_W-1:0]       eff_ftw;
    logic [WAVE_W-1:0]        eff_wave;
    logic                     start_ok;
    logic                     in_run;
    logic                     burst_end;
    logic                     drain_go;
    logic                     drain_last;
    logic [ADDR_W-1:0]        next_msb;
    logic                     wrap;

    assign cfg_ready = (state_reg == IDLE);
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign in_run    = (state_reg == RUN);

    // A config offered together with start is used by that start.
    assign eff_ftw  = cfg_fire ? cfg_ftw  : ftw_reg;
    assign eff_wave = cfg_fire ? cfg_wave : wave_reg;
    assign start_ok = (state_reg == IDLE) && start && (eff_ftw != '0);

    da_phase_acc #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W)
    ) u_phase_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok),
        .enable   (in_run),
        .ftw      (ftw_reg),
        .next_msb (next_msb),
        .wrap     (wrap)
    );

    assign cnt_inc    = period_cnt_reg + BURST_W'(1);
    assign burst_end  = wrap && (burst_reg != '0) && (cnt_inc == burst_reg);
    // Stop and burst-end landing on the same wrap collapse into one DRAIN.
    assign drain_go   = in_run && wrap && (burst_end || stop || stop_pend_reg);
    assign drain_last = (state_reg == DRAIN) && (drain_cnt_reg == 1'(DRAIN_CLKS - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok)   state_next = RUN;
            RUN:     if (drain_go)   state_next = DRAIN;
            DRAIN:   if (drain_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_reg   <= '0;
            wave_reg  <= '0;
            burst_reg <= '0;
        end else if (cfg_fire) begin
            ftw_reg   <= cfg_ftw;
            wave_reg  <= cfg_wave;
            burst_reg <= cfg_burst;
        end
    end

    // Period counter saturates rather than wrapping in long continuous runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_reg <= '0;
        end else if (start_ok) begin
            period_cnt_reg <= '0;
        end else if (wrap && (period_cnt_reg != '1)) begin
            period_cnt_reg <= cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_pend_reg <= 1'b0;
            drain_cnt_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            stop_pend_reg <= (in_run && !drain_go) ? (stop_pend_reg | stop) : 1'b0;
            drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 1'b1 : 1'b0;
            done_reg      <= drain_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_reg <= '0;
        end else if (start_ok) begin
            rom_addr_reg <= {eff_wave, ADDR_W'(0)};
        end else if (in_run) begin
            rom_addr_reg <= {wave_reg, next_msb};
        end
    end

    // rom_data lags rom_addr by one clock, so v1 tags which ROM words belong
    // to RUN; da_data_reg is the second pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg      <= 1'b0;
            da_data_reg <= MID;
        end else begin
            v1_reg      <= in_run;
            da_data_reg <= v1_reg ? rom_data : MID;
        end
    end

    assign rom_addr = rom_addr_reg;
    assign da_data  = da_data_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_da_wave_ctrl.sv
// Self-checking bench for da_wave_ctrl with a behavioural ROM and a queue of
// expected DA samples.
module tb_da_wave_ctrl;
    import da_wave_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_ftw;
    logic [1:0]  cfg_wave;
    logic [15:0] cfg_burst;
    logic        start;
    logic        stop;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  da_data;
    logic        busy;
    logic        done;

    logic [7:0]  rom_mem [0:1023];
    logic [9:0]  last_addr;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    da_wave_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ftw   (cfg_ftw),
        .cfg_wave  (cfg_wave),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .da_data   (da_data),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [23:0] f, input logic [1:0] w, input logic [15:0] b);
        cfg_valid = 1'b1;
        cfg_ftw   = f;
        cfg_wave  = w;
        cfg_burst = b;
        check_eq("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        tick();
    endtask

    // Starts a run, then tracks it cycle by cycle against a bench-side phase
    // model until the done pulse has passed.
    task automatic play(input logic [1:0] w, input logic [23:0] f, input logic [15:0] b,
                        input int stop_at, input bit bypass, input int exp_len);
        logic [24:0] sum;
        logic [23:0] ph;
        logic [9:0]  ea;
        logic [7:0]  exp_da;
        logic [7:0]  q [$];
        int          cnt;
        bit          pend;
        bit          running;
        bit          exp_busy;
        int          end_k;
        int          busy_cnt;
        int          done_cnt;
        ph = '0; cnt = 0; pend = 0; end_k = -1; busy_cnt = 0; done_cnt = 0;
        q.push_back(DA_MID);
        q.push_back(DA_MID);
        if (bypass) begin
            cfg_valid = 1'b1;
            cfg_ftw   = f;
            cfg_wave  = w;
            cfg_burst = b;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (k > 0) tick();
            if (k > 0 && end_k < 0) begin
                sum = {1'b0, ph} + {1'b0, f};
                ph  = sum[23:0];
                if (k - 1 == stop_at) pend = 1;
                if (sum[24]) begin
                    cnt++;
                    if ((b != 0 && cnt == int'(b)) || pend) begin
                        end_k = k;
                        last_addr = {w, ph[23:16]};
                    end
                end
            end
            running = (end_k < 0);
            ea = {w, ph[23:16]};
            if (running) check_eq("rom_addr", 32'(rom_addr), 32'(ea));
            else         check_eq("rom_addr_hold", 32'(rom_addr), 32'(last_addr));
            exp_da = q.pop_front();
            check_eq("da_data", 32'(da_data), 32'(exp_da));
            q.push_back(running ? rom_mem[ea] : DA_MID);
            exp_busy = running || (k <= end_k + 1);
            check_eq("busy", 32'(busy), 32'(exp_busy));
            check_eq("done", 32'(done), 32'(end_k >= 0 && k == end_k + 2));
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (running && k >= 3 && k <= 5) begin
                check_eq("cfg_ready_run", 32'(cfg_ready), 32'd0);
                cfg_valid = 1'b1;
                cfg_ftw   = 24'h000001;
                cfg_wave  = ~w;
                cfg_burst = 16'd1;
            end else begin
                cfg_valid = 1'b0;
            end
            stop = (k == stop_at);
            if (end_k >= 0 && k == end_k + 3) break;
        end
        stop = 1'b0;
        cfg_valid = 1'b0;
        check_eq("run_ended", 32'(end_k >= 0), 32'd1);
        check_eq("busy_len", 32'(busy_cnt), 32'(exp_len));
        check_eq("done_count", 32'(done_cnt), 32'd1);
        $display("run wave=%0d ftw=0x%06h burst=%0d stop_at=%0d end_clk=%0d busy_clks=%0d",
                 w, f, b, stop_at, end_k, busy_cnt);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'((i * 37) ^ (i >> 2) ^ 8'h5A);
        last_addr = '0;
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_ftw = '0; cfg_wave = '0; cfg_burst = '0;
        start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
        check_eq("rst_da_data", 32'(da_data), 32'h80);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Continuous run at step 1, stopped mid-period: ends at the wrap at 512.
        load_cfg(24'h010000, 2'd1, 16'd0);
        play(2'd1, 24'h010000, 16'd0, 300, 1'b0, 514);
        // Burst of three periods at step 2.
        load_cfg(24'h020000, 2'd1, 16'd3);
        play(2'd1, 24'h020000, 16'd3, -1, 1'b0, 386);
        // Non-integer period, stop mid-period.
        load_cfg(24'h300000, 2'd3, 16'd0);
        play(2'd3, 24'h300000, 16'd0, 7, 1'b0, 13);
        // Config offered with start: new step 4 used immediately.
        play(2'd2, 24'h040000, 16'd2, -1, 1'b1, 130);
        // Stop pending when the burst ends on the same wrap.
        load_cfg(24'h020000, 2'd1, 16'd2);
        play(2'd1, 24'h020000, 16'd2, 200, 1'b0, 258);
        // Large ftw wrapping on most clocks.
        load_cfg(24'hC00001, 2'd0, 16'd5);
        play(2'd0, 24'hC00001, 16'd5, -1, 1'b0, 9);

        // Start with a zero tuning word is ignored.
        load_cfg(24'h000000, 2'd2, 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("ftw0_busy", 32'(busy), 32'd0);
            check_eq("ftw0_da", 32'(da_data), 32'h80);
            check_eq("ftw0_addr", 32'(rom_addr), 32'(last_addr));
            tick();
        end
        $display("ftw0 start ignored busy=%0d da_data=0x%02h", busy, da_data);

        // Asynchronous reset in the middle of a run.
        load_cfg(24'h010000, 2'd1, 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_rom_addr", 32'(rom_addr), 32'd0);
        check_eq("arst_da_data", 32'(da_data), 32'h80);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_cfg_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("arst_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_done", 32'(done), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("post_rst_ftw0", 32'(busy), 32'd0);
        $display("reset mid-run rom_addr=0x%03h busy=%0d", rom_addr, busy);
        tick();
        load_cfg(24'h010000, 2'd1, 16'd0);
        play(2'd1, 24'h010000, 16'd0, 10, 1'b0, 258);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
